// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Wide enough for any practical DATA_W; callers truncate to their width.
  localparam int RST_VAL_W = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Each register powers up holding its own index, which makes
  // address-decode faults visible on the very first reads.
  function automatic logic [RST_VAL_W-1:0] reset_val(input int idx);
    return RST_VAL_W'(idx);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between decode/writeback (master) and the register file (slave).
//
// Handshake: there is no valid/ready pair and no backpressure. rd_en and
// wr_en qualify their address/data for exactly the cycle they are high and
// are consumed at that rising edge. While busy is high, writes are discarded
// and reported by a one-cycle wr_drop pulse on the following cycle; reads
// are always accepted. clr_req is only acted upon while the clear FSM idles.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;
  clr_state_e        clr_state;   // debug view of the clear FSM

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data_a, rd_data_b, busy, wr_drop, clr_state
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
    output rd_data_a, rd_data_b, busy, wr_drop, clr_state
  );

endinterface

// File: rtl/reg_file_clr_seq.sv
// Bulk-clear sequencer: sweeps every index once, one per cycle, and flags
// writes that arrive while the sweep is running.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              wr_en,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output clr_state_e        state
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q;

  // State, sweep counter and drop flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_en && (state_q == ST_CLEAR);
    end
  end

  // Next state and clear strobe; the all-ones count is the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign wr_drop  = wr_drop_q;
  assign clr_addr = cnt_q;
  assign state    = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with optional zero register,
// optional write/clear forwarding and a background bulk clear.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_eff;

  reg_file_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .wr_en    (bus.wr_en),
    .busy     (busy),
    .wr_drop  (bus.wr_drop),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (bus.clr_state)
  );

  assign bus.busy = busy;

  // A write only lands while idle and never into the hardwired zero entry.
  assign wr_eff = bus.wr_en && !busy &&
                  !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Storage; clear and normal writes are mutually exclusive by FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(reset_val(i));
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_eff) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] q;

    assign addr = (p == 0) ? bus.rd_addr_a : bus.rd_addr_b;

    // Read value selection: zero reg, then write forward, then clear forward.
    always_comb begin
      nxt = mem[addr];
      if ((ZERO_REG != 0) && (addr == '0)) begin
        nxt = '0;
      end else if ((BYPASS != 0) && wr_eff && (bus.wr_addr == addr)) begin
        nxt = bus.wr_data;
      end else if ((BYPASS != 0) && clr_we && (clr_addr == addr)) begin
        nxt = '0;
      end
    end

    // Registered read data, held while rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else if (bus.rd_en) q <= nxt;
    end
  end

  assign bus.rd_data_a = g_port[0].q;
  assign bus.rd_data_b = g_port[1].q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed and random steps against an array model
// in which a forwarded read simply sees the register's post-edge value.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [32];
  bit          clr_on;
  int          clr_idx;
  logic [31:0] exp_a, exp_b;
  bit          exp_drop;
  int          busy_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = i;
    clr_on   = 1'b0;
    clr_idx  = 0;
    exp_a    = '0;
    exp_b    = '0;
    exp_drop = 1'b0;
  endtask

  task automatic drive_idle();
    bus.rd_en     = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_req   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rd_a"}, bus.rd_data_a, exp_a);
    check({tag, "_rd_b"}, bus.rd_data_b, exp_b);
    check({tag, "_busy"}, 32'(bus.busy), 32'(clr_on));
    check({tag, "_drop"}, 32'(bus.wr_drop), 32'(exp_drop));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, advance the model, check after the edge.
  task automatic step(input bit rd, input int aa, input int ab, input bit we,
                      input int wa, input logic [31:0] wd, input bit cr);
    @(negedge clk);
    bus.rd_en     = rd;
    bus.rd_addr_a = aa[4:0];
    bus.rd_addr_b = ab[4:0];
    bus.wr_en     = we;
    bus.wr_addr   = wa[4:0];
    bus.wr_data   = wd;
    bus.clr_req   = cr;
    exp_drop = we && clr_on;
    if (clr_on) begin
      model[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == 32) clr_on = 1'b0;
    end else begin
      if (we && wa != 0) model[wa] = wd;
      if (cr) begin
        clr_on  = 1'b1;
        clr_idx = 0;
      end
    end
    if (rd) begin
      exp_a = model[aa];
      exp_b = model[ab];
    end
    @(posedge clk);
    #1;
    check_outputs("step");
  endtask

  task automatic rand_step(input int clr_odds);
    step(($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
         ($urandom_range(0, 1) == 1), $urandom_range(0, 31), $urandom(),
         (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int aa, ab, wa;
    bit we, cr;
    logic [31:0] wd;

    apply_reset();

    // Reset contents are the indices.
    step(1, 5, 31, 0, 0, 0, 0);
    check("tp1_a", bus.rd_data_a, 32'd5);
    check("tp1_b", bus.rd_data_b, 32'd31);

    // Same-cycle write forwarded to the read port.
    step(1, 7, 7, 1, 7, 32'hDEAD_BEEF, 0);
    check("tp2_bypass", bus.rd_data_a, 32'hDEAD_BEEF);
    step(1, 7, 2, 0, 0, 0, 0);
    check("tp2_stored", bus.rd_data_a, 32'hDEAD_BEEF);

    // Register 0 ignores writes.
    step(0, 0, 0, 1, 0, 32'h1234, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("tp3_zero", bus.rd_data_a, 32'd0);

    repeat (200) rand_step(0);

    // Bulk clear with reads, a dropped write and an ignored re-request.
    step(0, 0, 0, 1, 3, 32'd3, 0);
    step(1, 3, 5, 0, 0, 0, 1);
    busy_cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      aa = $urandom_range(0, 31);
      ab = $urandom_range(0, 31);
      we = 1'b0; wa = 0; wd = '0; cr = 1'b0;
      if (k == 1 || k == 10) aa = 3;
      if (k == 20) begin we = 1'b1; wa = 9; wd = $urandom(); end
      if (k == 25) cr = 1'b1;
      step(1, aa, ab, we, wa, wd, cr);
      busy_cycles++;
      if (k == 1)  check("tp4_c1_addr3", bus.rd_data_a, 32'd3);
      if (k == 10) check("tp4_c10_addr3", bus.rd_data_a, 32'd0);
      if (k == 20) check("tp5_drop", 32'(bus.wr_drop), 32'd1);
      if (!bus.busy) break;
    end
    check("tp4_busy_len", 32'(busy_cycles), 32'd32);
    for (int i = 0; i < 32; i += 2) step(1, i, i + 1, 0, 0, 0, 0);
    step(1, 9, 9, 0, 0, 0, 0);
    check("tp5_reg9", bus.rd_data_a, 32'd0);

    // Mixed random traffic with occasional clears.
    repeat (300) rand_step(40);
    for (int k = 0; k < 40 && clr_on; k++) rand_step(0);

    // Reset in the middle of a sweep.
    step(1, 1, 2, 0, 0, 0, 1);
    for (int k = 1; k <= 11; k++) rand_step(0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("tp6_busy", 32'(bus.busy), 32'd0);
    check("tp6_rd_a", bus.rd_data_a, 32'd0);
    check("tp6_rd_b", bus.rd_data_b, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 20, 4, 0, 0, 0, 0);
    check("tp6_addr20", bus.rd_data_a, 32'd20);
    check("tp6_addr4", bus.rd_data_b, 32'd4);

    repeat (50) rand_step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised, multi-port successor to the CPU register file: two registered read ports, one write port, an optional hardwired zero register, and optional write-to-read bypass. Adds a bulk-clear sequencer that zeroes the whole array over DEPTH cycles while reads continue. Sits between decode (read addresses) and writeback (write port) in the datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write or clear to the read address is forwarded to read data

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  update both read-data registers this cycle
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  registered read data A
rd_data_b  out  DATA_W  registered read data B
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr_req  in  1  start bulk clear (sampled in IDLE only)
busy  out  1  clear sequence in progress
wr_drop  out  1  one-cycle pulse: a write was discarded because busy

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port clk, reset port rst_n.
- Reset (rst_n=0, immediate): reg[i] = i zero-extended to DATA_W; rd_data_a/b = 0; busy = 0; wr_drop = 0; FSM = IDLE; clear counter = 0.
- Write: at posedge, if wr_en and FSM=IDLE and not (ZERO_REG and wr_addr=0), then reg[wr_addr] <= wr_data. All other writes have no effect.
- Read: 1-cycle latency. At posedge with rd_en=1, rd_data_x <= value of reg[rd_addr_x]. With rd_en=0, rd_data holds.
- Read value selection, in priority order:
  1. ZERO_REG and addr=0 -> 0.
  2. BYPASS and an effective write to the same address this cycle -> wr_data.
  3. BYPASS and the clear sequencer writes the same address this cycle -> 0.
  4. Otherwise the stored pre-edge value.
- With BYPASS=0, a same-cycle read returns the old value.
- Both ports may read the same address; each port resolves independently.
- FSM states IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1; counter <= 0; busy rises the next cycle.
  - In CLEAR, each cycle reg[counter] <= 0 and counter increments; busy = 1.
  - After writing index DEPTH-1, go to IDLE. busy is high for exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored (no restart or extension).
- wr_en=1 while in CLEAR: write discarded, wr_drop = 1 on the next cycle. No queuing.
- Reads are allowed during CLEAR and return current contents: already-cleared entries = 0, uncleared entries = old value.
- Simultaneous clr_req and wr_en in IDLE: the write completes (the FSM is still IDLE that edge) and the clear starts. The written value is later zeroed by the sweep.
- Reset mid-CLEAR: abort immediately; all registers return to their reset values; FSM = IDLE.
- Counter is ADDR_W bits wide. Wrap-around at DEPTH-1 is the terminal condition, not an error.
- No X propagation: every address value is in range by construction.

Decomposition:
- Package reg_file_pkg holds:
  - FSM state encoding (ST_IDLE=0, ST_CLEAR=1)
  - default DATA_W/ADDR_W constants
  - a function computing the reset value of index i
- Sub-module reg_file_clr_seq holds the FSM, counter, busy, the clear write-enable/address strobe, and the wr_drop generation.
- The top holds the storage array, write gating, and the per-port read/bypass muxes. The bypass mux is instantiated once per port via a generate loop.

Test Plan:
1. Reset, then rd_en=1, rd_addr_a=5, rd_addr_b=31 -> next cycle rd_data_a=5, rd_data_b=31.
2. wr_en=1, wr_addr=7, wr_data=0xDEADBEEF while rd_addr_a=7, rd_en=1 -> BYPASS=1: rd_data_a=0xDEADBEEF next cycle; BYPASS=0: 7 next cycle, then 0xDEADBEEF one cycle later.
3. wr_en=1, wr_addr=0, wr_data=0x1234, then read addr 0 -> 0 with ZERO_REG=1; 0x1234 with ZERO_REG=0.
4. Pulse clr_req in IDLE -> busy high for exactly 32 cycles. Read addr 3 at clear cycle 1 -> 3; at cycle 10 -> 0. After busy falls, all 32 entries read 0.
5. wr_en=1, wr_addr=9 during CLEAR cycle 20 -> wr_drop pulses once, reg 9 stays 0. clr_req at cycle 25 -> busy still falls after cycle 32.
6. Assert rst_n=0 at CLEAR cycle 12 -> busy=0 and rd_data=0 immediately. After release, a read of addr 20 returns 20 and a read of addr 4 returns 4.
